// File: rtl/hmmm_boot_mem.sv
// HMMM unified 256 x 15-bit memory with a length-prefixed byte-stream boot loader.
// The core is held in reset while an image streams in, then it gets combinational reads and byte stores.
module hmmm_boot_mem #(
    parameter int ADDR_W = 8,
    parameter int HI_W   = 7,
    parameter int LO_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [LO_W-1:0]        ld_data,
    input  logic                   ld_start,
    output logic                   cpu_hold,
    input  logic [ADDR_W-1:0]      cpu_adr,
    input  logic                   cpu_we,
    input  logic [LO_W-1:0]        cpu_wdata,
    output logic [HI_W+LO_W-1:0]   cpu_rdata,
    output logic [ADDR_W:0]        ld_count
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {ST_CNT, ST_HI, ST_LO, ST_RUN} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       ptr;
    logic [ADDR_W:0]         remaining;
    logic [HI_W-1:0]         hi_reg;
    logic [HI_W+LO_W-1:0]    mem [DEPTH];
    logic                    loader_we;
    logic                    store_we;

    // Loader and core never write in the same cycle: one is only active in LO, the other only in RUN.
    assign loader_we = reset && (state == ST_LO) && ld_valid;
    assign store_we  = reset && (state == ST_RUN) && cpu_we;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_CNT;
            cpu_hold  <= 1'b1;
            ld_ready  <= 1'b1;
            ld_count  <= '0;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_CNT: if (ld_valid) begin
                    // A count byte of zero means a full-depth image.
                    remaining <= (ld_data == '0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(ld_data);
                    ptr       <= '0;
                    ld_count  <= '0;
                    state     <= ST_HI;
                end
                ST_HI: if (ld_valid) begin
                    hi_reg <= ld_data[HI_W-1:0];
                    state  <= ST_LO;
                end
                ST_LO: if (ld_valid) begin
                    ptr       <= ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    ld_count  <= ld_count + 1'b1;
                    if (remaining == (ADDR_W+1)'(1)) begin
                        state    <= ST_RUN;
                        cpu_hold <= 1'b0;
                        ld_ready <= 1'b0;
                    end else begin
                        state <= ST_HI;
                    end
                end
                ST_RUN: if (ld_start) begin
                    state    <= ST_CNT;
                    cpu_hold <= 1'b1;
                    ld_ready <= 1'b1;
                    ld_count <= '0;
                end
                default: state <= ST_CNT;
            endcase
        end
    end

    // NOTE: the memory array has no reset; an abandoned load keeps whatever it already wrote.
    always_ff @(posedge clk) begin
        if (loader_we)
            mem[ptr] <= {hi_reg, ld_data};
        if (store_we)
            mem[cpu_adr][LO_W-1:0] <= cpu_wdata;
    end

    assign cpu_rdata = mem[cpu_adr];

endmodule
